// File: rtl/series_ctrl.sv
// Sequencing FSM for the 16-bit series-evaluation datapath: INIT, FIRST, then (ACC, MULX, MULC) loops until the last term, then DONE.
// Optional early termination on a small term is compiled in with `define SERIES_EARLY_TERM_EN.
module series_ctrl #(
    parameter bit ALT_SIGN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cnt_done,
    input  logic gt,
    output logic counter_en,
    output logic cnt_clr,
    output logic sel_x,
    output logic load_x,
    output logic sel_1,
    output logic sel_2,
    output logic load_m,
    output logic sel_t,
    output logic load_t,
    output logic mode,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FIRST = 3'd2,
        S_ACC   = 3'd3,
        S_MULX  = 3'd4,
        S_MULC  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   parity_q, parity_d;
    logic   last_term;

`ifdef SERIES_EARLY_TERM_EN
    // A term at or below threshold ends the series once it has been accumulated.
    assign last_term = cnt_done | ~gt;
`else
    logic unused_gt;
    assign unused_gt = gt;
    assign last_term = cnt_done;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT: begin
                state_d  = S_FIRST;
                parity_d = 1'b0;
            end
            S_FIRST: state_d = S_ACC;
            S_ACC: begin
                if (last_term) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_MULX;
                    parity_d = ~parity_q;
                end
            end
            S_MULX:  state_d = S_MULC;
            S_MULC:  state_d = S_ACC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        counter_en = 1'b0;
        cnt_clr    = 1'b0;
        sel_x      = 1'b0;
        load_x     = 1'b0;
        sel_1      = 1'b0;
        sel_2      = 1'b0;
        load_m     = 1'b0;
        sel_t      = 1'b0;
        load_t     = 1'b0;
        mode       = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_INIT: begin
                load_x  = 1'b1;
                load_t  = 1'b1;
                cnt_clr = 1'b1;
            end
            S_FIRST: begin
                sel_2  = 1'b1;
                load_m = 1'b1;
            end
            S_ACC: begin
                load_t     = 1'b1;
                sel_t      = 1'b1;
                mode       = ALT_SIGN & parity_q;
                counter_en = ~last_term;
            end
            S_MULX: begin
                sel_1  = 1'b1;
                load_m = 1'b1;
            end
            S_MULC: begin
                sel_1  = 1'b1;
                sel_2  = 1'b1;
                load_m = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
